// File: rtl/alarm_pkg.sv
// Shared time-field layout, FSM state encoding and default parameters
// for the alarm scheduler.
package alarm_pkg;

  localparam int TIME_W   = 17;
  localparam int HOUR_MSB = 16;
  localparam int HOUR_LSB = 12;
  localparam int MIN_MSB  = 11;
  localparam int MIN_LSB  = 6;
  localparam int SEC_MSB  = 5;
  localparam int SEC_LSB  = 0;

  localparam int CNT_W = 16;

  localparam int DEF_NUM_ALARMS  = 4;
  localparam int DEF_RING_SECS   = 60;
  localparam int DEF_SNOOZE_SECS = 300;
  localparam int DEF_MAX_SNOOZE  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  // Slots may hold impossible times such as 25:00:00; those must never fire.
  function automatic logic time_valid(input logic [TIME_W-1:0] t);
    return (t[HOUR_MSB:HOUR_LSB] <= 5'd23) &&
           (t[MIN_MSB:MIN_LSB]   <= 6'd59) &&
           (t[SEC_MSB:SEC_LSB]   <= 6'd59);
  endfunction

endpackage

// File: rtl/alarm_ring_timer.sv
// Loadable seconds down-counter shared by the ring and snooze phases;
// zero flags terminal count.
module alarm_ring_timer
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm slot array, single shared time comparator scanned once per second,
// and the ring/snooze/dismiss FSM driving the buzzer request.
//
// state   | meaning
// IDLE    | no event; scanner may run after each SEC_TICK
// RINGING | buzzer requested, ring timer counting down
// SNOOZED | buzzer silent, snooze timer counting down
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = DEF_NUM_ALARMS,
  parameter int RING_SECS   = DEF_RING_SECS,
  parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
  parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SEC_TICK,
  input  logic [TIME_W-1:0] CURRENT_TIME,
  input  logic              WR_EN,
  input  logic [IDX_W-1:0]  WR_IDX,
  input  logic [TIME_W-1:0] WR_TIME,
  input  logic              WR_ENABLE,
  input  logic              SNOOZE,
  input  logic              DISMISS,
  output logic              ALARM_DOING,
  output logic              SNOOZE_ACTIVE,
  output logic [IDX_W-1:0]  ACTIVE_IDX
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] slot_time_q [NUM_ALARMS];
  logic [TIME_W-1:0] slot_time_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_q, slot_en_d;
  logic [TIME_W-1:0] cap_time_q, cap_time_d;
  logic              scan_arm_q, scan_arm_d;
  logic              scan_run_q, scan_run_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]  active_idx_q, active_idx_d;
  logic [7:0]        snz_cnt_q, snz_cnt_d;

  logic             timer_load, timer_zero;
  logic [CNT_W-1:0] timer_val;
  logic             scan_start, scan_hit, match, kill_active;

  alarm_ring_timer u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (SEC_TICK),
    .zero     (timer_zero)
  );

  assign scan_start  = (state_q == IDLE) && SEC_TICK;
  assign scan_hit    = scan_run_q && slot_en_q[scan_idx_q] &&
                       (slot_time_q[scan_idx_q] == cap_time_q) && time_valid(cap_time_q);
  // A new tick restarts the scan, so a hit in that same cycle is stale.
  assign match       = scan_hit && !scan_start;
  assign kill_active = WR_EN && !WR_ENABLE && (WR_IDX == active_idx_q);

  always_comb begin
    slot_time_d = slot_time_q;
    slot_en_d   = slot_en_q;
    if (WR_EN) begin
      slot_time_d[WR_IDX] = WR_TIME;
      slot_en_d[WR_IDX]   = WR_ENABLE;
    end
  end

  always_comb begin
    cap_time_d = cap_time_q;
    scan_arm_d = 1'b0;
    scan_run_d = scan_run_q;
    scan_idx_d = scan_idx_q;
    if (scan_start) begin
      cap_time_d = CURRENT_TIME;
      scan_arm_d = 1'b1;
      scan_run_d = 1'b0;
    end else if (scan_arm_q) begin
      scan_run_d = 1'b1;
      scan_idx_d = '0;
    end else if (scan_run_q) begin
      if (scan_hit || (scan_idx_q == IDX_W'(NUM_ALARMS - 1))) begin
        scan_run_d = 1'b0;
      end else begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    active_idx_d = active_idx_q;
    snz_cnt_d    = snz_cnt_q;
    timer_load   = 1'b0;
    timer_val    = '0;
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d      = RINGING;
          active_idx_d = scan_idx_q;
          snz_cnt_d    = '0;
          timer_load   = 1'b1;
          timer_val    = CNT_W'(RING_SECS);
        end
      end
      RINGING: begin
        if (DISMISS || kill_active) begin
          state_d = IDLE;
        end else if (SNOOZE && (snz_cnt_q < 8'(MAX_SNOOZE))) begin
          state_d    = SNOOZED;
          snz_cnt_d  = snz_cnt_q + 8'd1;
          timer_load = 1'b1;
          timer_val  = CNT_W'(SNOOZE_SECS);
        end else if (timer_zero) begin
          state_d = IDLE;
        end
      end
      SNOOZED: begin
        if (DISMISS || kill_active) begin
          state_d = IDLE;
        end else if (timer_zero) begin
          state_d    = RINGING;
          timer_load = 1'b1;
          timer_val  = CNT_W'(RING_SECS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_time_q[i] <= '0;
      end
      slot_en_q    <= '0;
      cap_time_q   <= '0;
      scan_arm_q   <= 1'b0;
      scan_run_q   <= 1'b0;
      scan_idx_q   <= '0;
      active_idx_q <= '0;
      snz_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_time_q  <= slot_time_d;
      slot_en_q    <= slot_en_d;
      cap_time_q   <= cap_time_d;
      scan_arm_q   <= scan_arm_d;
      scan_run_q   <= scan_run_d;
      scan_idx_q   <= scan_idx_d;
      active_idx_q <= active_idx_d;
      snz_cnt_q    <= snz_cnt_d;
    end
  end

  assign ALARM_DOING   = (state_q == RINGING);
  assign SNOOZE_ACTIVE = (state_q == SNOOZED);
  assign ACTIVE_IDX    = active_idx_q;

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Holds `NUM_ALARMS` programmable alarm slots and shares a single time comparator between them by scanning the slots once per second tick. It runs the ring/snooze/dismiss state machine that drives the buzzer request. It sits between the timekeeping counter (`CURRENT_TIME`, `SEC_TICK`) and the buzzer/LED output logic. It supersedes per-slot comparators in the alarm path.

## Interface
Parameters:
- `NUM_ALARMS`, 4: number of alarm slots, 1..16.
- `RING_SECS`, 60: seconds a ring lasts before it stops on its own.
- `SNOOZE_SECS`, 300: snooze length in seconds.
- `MAX_SNOOZE`, 3: snoozes allowed per ring event; further SNOOZE presses are ignored.

Ports:
- `CLK` in 1: system clock. One clock domain.
- `RESET` in 1: asynchronous, active-high reset.
- `SEC_TICK` in 1: one-cycle pulse, asserted in the same cycle that `CURRENT_TIME` holds the new second.
- `CURRENT_TIME` in 17: packed {hour[16:12], min[11:6], sec[5:0]}.
- `WR_EN` in 1: slot write strobe.
- `WR_IDX` in clog2(NUM_ALARMS): slot to write.
- `WR_TIME` in 17: alarm time, same packing as `CURRENT_TIME`.
- `WR_ENABLE` in 1: slot enable bit to store.
- `SNOOZE` in 1: one-cycle pulse, debounced upstream.
- `DISMISS` in 1: one-cycle pulse, debounced upstream.
- `ALARM_DOING` out 1: buzzer request.
- `SNOOZE_ACTIVE` out 1: high while in SNOOZED.
- `ACTIVE_IDX` out clog2(NUM_ALARMS): slot that triggered the current event.

## Operation
- Slot array: NUM_ALARMS × {time[16:0], en}.
  - Reset clears all slots to time 0, en 0.
  - A write lands at the clock edge and is visible to a compare in the next cycle.
  - Out-of-range times, such as hour > 23, are stored as-is. They never match.
- Scanner:
  - On a `SEC_TICK` while in IDLE, it latches `CURRENT_TIME` into `cap_time` and compares slot i at scan cycle i.
  - It stops at the first enabled exact match, so the lowest index wins.
  - A `SEC_TICK` during a scan restarts the scan from slot 0 with the new time.
  - `SEC_TICK` in RINGING or SNOOZED does not start a scan.
- FSM states: IDLE, RINGING, SNOOZED.
  - IDLE → RINGING on a scan match. `ACTIVE_IDX` is loaded, the ring counter is set to RING_SECS, and the snooze count is set to 0.
  - RINGING: the ring counter decrements on each `SEC_TICK`.
    - When it reaches 0, go to IDLE.
    - SNOOZE with snooze count < MAX_SNOOZE: go to SNOOZED, load the counter with SNOOZE_SECS, and increment the snooze count.
  - SNOOZED: the counter decrements on `SEC_TICK`. When it reaches 0, go to RINGING with the counter reloaded to RING_SECS.
  - DISMISS in RINGING or SNOOZED: go to IDLE.
  - DISMISS and SNOOZE in the same cycle: DISMISS wins.
  - A write of en=0 to `ACTIVE_IDX` while not IDLE terminates the event and returns to IDLE. A write of en=1 with a new time does not terminate it.
- Outputs:
  - `ALARM_DOING` is 1 only in RINGING.
  - `SNOOZE_ACTIVE` is 1 only in SNOOZED.
  - `ACTIVE_IDX` holds its last value in IDLE.
- Reset values: `ALARM_DOING` 0, `SNOOZE_ACTIVE` 0, `ACTIVE_IDX` 0. FSM in IDLE, counters 0, scan not running.

## Timing
- `SEC_TICK` at edge T captures the time. Slot i is compared in cycle T+1+i. On a match, `ALARM_DOING` is 1 from edge T+2+i.
- Constraint: NUM_ALARMS+2 cycles must be shorter than the tick period. This always holds for a 1 Hz tick.
- SNOOZE or DISMISS at edge T: outputs change at edge T+1.
- Counter expiry:
  - The tick that makes the counter 0 causes the state change at the next edge.
  - The ring therefore lasts exactly RING_SECS ticks.
  - A ring that starts mid-second counts the partial second as not elapsed.
- Asynchronous RESET mid-ring: outputs drop immediately. Slot contents are lost.

## Structure
- Shared package `alarm_pkg` holds:
  - the time field widths and offsets (HOUR_MSB..SEC_LSB, TIME_W=17);
  - the state enum {IDLE, RINGING, SNOOZED};
  - the default parameter constants.
- One sub-module, `alarm_ring_timer`: a loadable down counter decremented by `SEC_TICK`, with a `zero` flag. It is shared by the RINGING and SNOOZED phases.
- Slot array, scanner and FSM live in `alarm_scheduler`.

## Test plan
- Write slot 2 = 07:30:00 with en=1, then drive ticks up to 07:30:00 → `ALARM_DOING` rises at T+4, `ACTIVE_IDX`=2.
- Slots 1 and 3 both set to 06:00:00 with en=1 → `ACTIVE_IDX`=1; no second event follows the dismiss.
- Ring with no input → `ALARM_DOING` falls after exactly 60 ticks.
- SNOOZE ×3 across expiries, then a 4th SNOOZE → 4th ignored; `ALARM_DOING` stays 1; each snooze lasts 300 ticks.
- SNOOZE and DISMISS in the same cycle → IDLE, `SNOOZE_ACTIVE` 0. Separately, write en=0 to the active slot while SNOOZED → IDLE at the next edge.
- Assert RESET while RINGING → `ALARM_DOING` 0 without a clock edge; all slots disabled; no match on a later tick.
